// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes, FSM state types and byte-lane merge.
package axil_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam int unsigned DATA_MAX    = 64;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  // Sized for the widest supported bus; callers zero-extend and truncate.
  function automatic logic [DATA_MAX-1:0] strb_merge(
    input logic [DATA_MAX-1:0]   old_w,
    input logic [DATA_MAX-1:0]   new_w,
    input logic [DATA_MAX/8-1:0] strb
  );
    logic [DATA_MAX-1:0] res;
    res = old_w;
    for (int unsigned k = 0; k < DATA_MAX/8; k++) begin
      if (strb[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite.sv
// AXI-Lite bus bundle; address width equals data width.
interface axi_lite #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [DATA_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI-Lite control/status register bank with independent write and read FSMs.
// Optional: define AXIL_REG_BANK_W1C_EN to make read-only registers sticky
// (set from stat_i, cleared by writing 1s).
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  axi_lite.slave                         s_axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] stat_i
);

  localparam int unsigned BYTES    = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(BYTES);
  localparam int unsigned IDX_W    = $clog2(NUM_REGS);

  wr_state_t             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [BYTES-1:0]      wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  rd_state_t             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0] stat_w [NUM_REGS];
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_in_range, rd_in_range;
  logic                  unused_prot;

  assign unused_prot = ^{s_axil.awprot, s_axil.arprot};

  assign wr_idx      = awaddr_q[ADDR_LSB +: IDX_W];
  assign wr_in_range = (awaddr_q >> (ADDR_LSB + IDX_W)) == '0;
  assign rd_idx      = s_axil.araddr[ADDR_LSB +: IDX_W];
  assign rd_in_range = (s_axil.araddr >> (ADDR_LSB + IDX_W)) == '0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_slice
    assign stat_w[g]                           = stat_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  // Write path: collect AW and W independently, commit once both are held.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (aw_held_q && w_held_q) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = WR_RESP;
          bvalid_d   = 1'b1;
          if (!wr_in_range) begin
            bresp_d = RESP_SLVERR;
          end else if (RO_MASK[wr_idx]) begin
`ifdef AXIL_REG_BANK_W1C_EN
            regs_d[wr_idx] = regs_q[wr_idx] &
              ~DATA_WIDTH'(strb_merge('0, DATA_MAX'(wdata_q), (DATA_MAX/8)'(wstrb_q)));
            wr_pulse_d[wr_idx] = 1'b1;
            bresp_d            = RESP_OKAY;
`else
            bresp_d = RESP_SLVERR;
`endif
          end else begin
            regs_d[wr_idx] = DATA_WIDTH'(strb_merge(DATA_MAX'(regs_q[wr_idx]),
              DATA_MAX'(wdata_q), (DATA_MAX/8)'(wstrb_q)));
            wr_pulse_d[wr_idx] = 1'b1;
            bresp_d            = RESP_OKAY;
          end
        end else begin
          if (s_axil.awvalid && awready_q) begin
            awaddr_d  = s_axil.awaddr;
            aw_held_d = 1'b1;
          end
          if (s_axil.wvalid && wready_q) begin
            wdata_d  = s_axil.wdata;
            wstrb_d  = s_axil.wstrb;
            w_held_d = 1'b1;
          end
        end
      end
      WR_RESP: begin
        if (s_axil.bready) begin
          wr_state_d = WR_IDLE;
          bvalid_d   = 1'b0;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
`ifdef AXIL_REG_BANK_W1C_EN
    // Status set is applied after the clear so a simultaneous set wins.
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (RO_MASK[i]) regs_d[i] = regs_d[i] | stat_w[i];
    end
`endif
    awready_d = (wr_state_d == WR_IDLE) && !aw_held_d;
    wready_d  = (wr_state_d == WR_IDLE) && !w_held_d;
  end

  // Read path: capture data and response at AR acceptance, hold until rready.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (s_axil.arvalid && arready_q) begin
          rd_state_d = RD_DATA;
          rvalid_d   = 1'b1;
          if (!rd_in_range) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            rresp_d = RESP_OKAY;
`ifdef AXIL_REG_BANK_W1C_EN
            rdata_d = regs_q[rd_idx];
`else
            rdata_d = RO_MASK[rd_idx] ? stat_w[rd_idx] : regs_q[rd_idx];
`endif
          end
        end
      end
      RD_DATA: begin
        if (s_axil.rready) begin
          rd_state_d = RD_IDLE;
          rvalid_d   = 1'b0;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    arready_d = (rd_state_d == RD_IDLE);
  end

  // State and registered outputs for both FSMs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= '0;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign s_axil.awready = awready_q;
  assign s_axil.wready  = wready_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = arready_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rdata_q;
  assign wr_pulse_o     = wr_pulse_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed self-checking bench for axil_reg_bank (16 x 32-bit, reg15 read-only).
module tb_axil_reg_bank;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*DW-1:0] ctrl_o;
  logic [NR-1:0]    wr_pulse_o;
  logic [NR*DW-1:0] stat_i;

  int checks = 0;
  int errors = 0;

  axi_lite #(.DATA_WIDTH(DW)) bus ();

  axil_reg_bank #(
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .RO_MASK   (16'h8000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axil    (bus),
    .ctrl_o    (ctrl_o),
    .wr_pulse_o(wr_pulse_o),
    .stat_i    (stat_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] creg(input int unsigned i);
    return ctrl_o[i*DW +: DW];
  endfunction

  task automatic do_write(input logic [DW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, output logic [1:0] resp,
                          output logic [NR-1:0] pulse, output logic tmo);
    logic aw_hs, w_hs;
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(negedge clk);
      if (aw_hs) bus.awvalid = 1'b0;
      if (w_hs)  bus.wvalid  = 1'b0;
      if (!bus.awvalid && !bus.wvalid) begin
        tmo = 1'b0;
        break;
      end
    end
    if (!tmo) begin
      tmo = 1'b1;
      for (int i = 0; i < 20; i++) begin
        if (bus.bvalid) begin
          tmo = 1'b0;
          break;
        end
        @(negedge clk);
      end
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    resp  = bus.bresp;
    pulse = wr_pulse_o;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [DW-1:0] addr, output logic [DW-1:0] data,
                         output logic [1:0] resp, output logic tmo);
    logic ar_hs;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ar_hs = bus.arready;
      @(negedge clk);
      if (ar_hs) begin
        tmo = 1'b0;
        break;
      end
    end
    bus.arvalid = 1'b0;
    if (!tmo) begin
      tmo = 1'b1;
      for (int i = 0; i < 20; i++) begin
        if (bus.rvalid) begin
          tmo = 1'b0;
          break;
        end
        @(negedge clk);
      end
    end
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  initial begin
    logic [1:0]    resp;
    logic [NR-1:0] pulse;
    logic [DW-1:0] rd;
    logic          tmo;

    rst         = 1'b1;
    stat_i      = '0;
    stat_i[15*DW +: DW] = 32'h1234_5678;
    bus.awaddr  = '0;
    bus.awprot  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arprot  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", bus.awready, 0);
    check("rst_wready",  bus.wready,  0);
    check("rst_arready", bus.arready, 0);
    check("rst_bvalid",  bus.bvalid,  0);
    check("rst_rvalid",  bus.rvalid,  0);
    check("rst_bresp",   bus.bresp,   0);
    check("rst_rresp",   bus.rresp,   0);
    check("rst_rdata",   bus.rdata,   0);
    check("rst_ctrl",    |ctrl_o,     0);
    check("rst_pulse",   wr_pulse_o,  0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", bus.awready, 1);
    check("post_rst_wready",  bus.wready,  1);
    check("post_rst_arready", bus.arready, 1);

    // AW and W together: bvalid two cycles after acceptance
    bus.awaddr = 32'h08; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("t1_awready_low", bus.awready, 0);
    check("t1_wready_low",  bus.wready,  0);
    check("t1_bvalid_early", bus.bvalid, 0);
    check("t1_pulse_early", wr_pulse_o, 0);
    @(negedge clk);
    check("t1_bvalid", bus.bvalid, 1);
    check("t1_bresp",  bus.bresp,  2'b00);
    check("t1_pulse",  wr_pulse_o, 16'h0004);
    check("t1_reg2",   creg(2),    32'hDEAD_BEEF);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("t1_bvalid_done", bus.bvalid, 0);
    check("t1_pulse_done",  wr_pulse_o, 0);
    check("t1_awready_back", bus.awready, 1);
    check("t1_wready_back",  bus.wready,  1);

    // W three cycles ahead of AW, single byte lane
    bus.wdata = 32'h0000_00AA; bus.wstrb = 4'h1; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_wready_held", bus.wready, 0);
      check("t2_awready_open", bus.awready, 1);
      if (i < 2) @(negedge clk);
    end
    bus.awaddr = 32'h08; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    check("t2_bvalid_early", bus.bvalid, 0);
    @(negedge clk);
    check("t2_bvalid", bus.bvalid, 1);
    check("t2_bresp",  bus.bresp,  2'b00);
    check("t2_pulse",  wr_pulse_o, 16'h0004);
    check("t2_reg2",   creg(2),    32'hDEAD_BEAA);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("t2_bvalid_done", bus.bvalid, 0);

    // Out-of-range read and write
    do_read(32'h40, rd, resp, tmo);
    check("t3_rd_tmo", tmo, 0);
    check("t3_rdata", rd, 0);
    check("t3_rresp", resp, 2'b10);
    do_write(32'h40, 32'hFFFF_FFFF, 4'hF, resp, pulse, tmo);
    check("t3_wr_tmo", tmo, 0);
    check("t3_bresp", resp, 2'b10);
    check("t3_pulse", pulse, 0);
    check("t3_reg0",  creg(0), 0);
    check("t3_reg2",  creg(2), 32'hDEAD_BEAA);

    // Read-only register, rready held low for 5 cycles
    bus.araddr = 32'h3C; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(negedge clk);
    bus.arvalid = 1'b0;
    stat_i[15*DW +: DW] = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      check("t4_rvalid_hold", bus.rvalid, 1);
      check("t4_rdata_hold",  bus.rdata,  32'h1234_5678);
      check("t4_rresp_hold",  bus.rresp,  2'b00);
      check("t4_arready_low", bus.arready, 0);
      @(negedge clk);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check("t4_rvalid_done", bus.rvalid, 0);
    stat_i[15*DW +: DW] = 32'h0;
    @(negedge clk);
    do_write(32'h3C, 32'hFFFF_0000, 4'hF, resp, pulse, tmo);
    check("t4_wr_tmo", tmo, 0);
    do_read(32'h3C, rd, resp, tmo);
    check("t4_rd_tmo", tmo, 0);
`ifdef AXIL_REG_BANK_W1C_EN
    check("t4_ro_bresp", resp, 2'b00);
    check("t4_ro_rdata", rd, 32'h0000_F67D);
`else
    check("t4_ro_rresp", resp, 2'b00);
    check("t4_ro_rdata", rd, 32'h0);
    do_write(32'h3C, 32'h1111_1111, 4'hF, resp, pulse, tmo);
    check("t4_ro_bresp", resp, 2'b10);
    check("t4_ro_pulse", pulse, 0);
`endif

    // Read accepted in the same cycle reg1 is updated
    do_write(32'h04, 32'h1, 4'hF, resp, pulse, tmo);
    check("t5_init_bresp", resp, 2'b00);
    check("t5_init_pulse", pulse, 16'h0002);
    bus.awaddr = 32'h04; bus.wdata = 32'h2; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 32'h04; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("t5_rvalid", bus.rvalid, 1);
    check("t5_rdata_old", bus.rdata, 32'h1);
    check("t5_bvalid", bus.bvalid, 1);
    check("t5_reg1_new", creg(1), 32'h2);
    bus.rready = 1'b1; bus.bready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0; bus.bready = 1'b0;
    do_read(32'h04, rd, resp, tmo);
    check("t5_rd_tmo", tmo, 0);
    check("t5_rdata_new", rd, 32'h2);

    // Reset while a write response is stalled
    bus.awaddr = 32'h0C; bus.wdata = 32'h55; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    check("t6_bvalid_stall", bus.bvalid, 1);
    check("t6_reg3", creg(3), 32'h55);
    rst = 1'b1;
    @(negedge clk);
    check("t6_bvalid_rst", bus.bvalid, 0);
    check("t6_ctrl_rst",   |ctrl_o,    0);
    check("t6_awready_rst", bus.awready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_awready", bus.awready, 1);
    check("t6_wready",  bus.wready,  1);
    check("t6_arready", bus.arready, 1);
    do_read(32'h08, rd, resp, tmo);
    check("t6_rd_tmo", tmo, 0);
    check("t6_reg2_cleared", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
